output_drain: RTL
=================

Name: output_drain

Overview:
- Reader counterpart to the pipeline's output-SRAM writer.
- Once Top signals completion of an image, the block reads the finished image back from the output SRAM (sram_2R1W, ReadAddress1/ReadBus1 port).
- It unpacks each 128-bit word into 16 pixels and streams them out over a valid/ready handshake at up to 1 pixel/cycle.
- It feeds the off-chip / host-side output path in place of post-run memory dumps.

Parameters:
- AddressSize, 16, SRAM address width.
- DataBusSize, 128, SRAM word width.
- PixelWidth, 8, pixel width; DataBusSize/PixelWidth = 16 pixels per word.
- Base0, 16'd0, first word of image 0.
- Base1, 16'd32768, first word of image 1.
- NumWords, 19200, words per image (307200 pixels).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- GlobalFlag  in  2  completion flag from Top: 01 = image 0 done, 10 = image 1 done.
- ReadAddressOut  out  AddressSize  read address to output SRAM port 1.
- ReadBusOut  in  DataBusSize  read data; valid exactly 1 cycle after address.
- PixelOut  out  PixelWidth  streamed pixel.
- PixelValid  out  1  PixelOut valid.
- PixelReady  in  1  downstream accept; transfer = PixelValid & PixelReady.
- FrameFirst  out  1  qualifies the first pixel of an image.
- FrameLast  out  1  qualifies the last pixel of an image.
- ImageId  out  1  image being streamed (0/1), stable for the whole frame.
- DrainDone  out  2  sticky per-image done bits: bit0 = image 0, bit1 = image 1.

Behaviour:
- Reset values: ReadAddressOut=0, PixelOut=0, PixelValid=0, FrameFirst=0, FrameLast=0, ImageId=0, DrainDone=0. FSM returns to IDLE, pending request cleared. Reset mid-frame abandons the frame; no further pixels are emitted.
- Trigger:
  - GlobalFlag is registered every cycle (GF_q).
  - A request fires when GlobalFlag!=GF_q and GlobalFlag is 01 or 10.
  - Value 11 or 00 is ignored.
- Request queue:
  - One-deep pending register.
  - A request arriving while busy is queued.
  - A second request while one is already pending is dropped, and the pending one is kept.
  - A request for an image whose DrainDone bit is already set is still served; re-streaming is allowed.
- FSM states:
  - IDLE: take a queued or new request. Load ImageId, set address = Base(ImageId), word count=0 -> FETCH.
  - FETCH: drive address, 1-cycle latency -> LOAD.
  - LOAD: capture ReadBusOut into CurWord, lane=0, PixelValid=1, FrameFirst=1. Issue prefetch of the next word if count<NumWords-1 -> STREAM.
  - STREAM:
    - PixelOut = CurWord[127-8*lane -: 8], so the MSB byte goes first.
    - The lane advances on transfer only.
    - Prefetched data is captured into NextWord in the cycle after its address is issued.
    - Transfer at lane 15: if more words remain, CurWord<=NextWord, lane=0, and the next prefetch is issued in the same cycle. No bubble.
    - Transfer at lane 15 of word NumWords-1 (FrameLast=1): -> DONE.
  - DONE:
    - PixelValid=0.
    - DrainDone[ImageId] set.
    - -> IDLE next cycle.
    - The pending request is serviced from IDLE the cycle after.
- Handshake rules:
  - PixelOut, FrameFirst and FrameLast are held stable while PixelValid & !PixelReady.
  - PixelValid never drops mid-frame once raised.
  - FrameFirst clears after its transfer.
- Latency: request edge to first PixelValid is 3 cycles (IDLE, FETCH, LOAD).
- Address is computed as Base + count, 16-bit. Base1 + 19199 = 51967, no wrap. The word counter is 15 bits and saturates at NumWords-1.
- ReadAddressOut holds its last value when not fetching.

Decomposition:
- Shared package (hist_pkg):
  - AddressSize, DataBusSize, PixelWidth.
  - Image base addresses and NumWords.
  - GlobalFlag encodings FLAG_IMG0=2'b01, FLAG_IMG1=2'b10.
  - drain state enum.
- One natural sub-module, word_unpacker: CurWord/NextWord registers plus lane mux. The FSM and request logic stay in output_drain.

Test Plan:
- Preload word0 of image 0 with 0x000102…0F and word1 with 0x101112…1F. Pulse GlobalFlag 00->01, PixelReady=1 -> first valid 3 cycles later. Pixels 0x00..0x1F arrive back to back with no gap at the word boundary. FrameFirst is on pixel 0 only.
- Full image 0 with PixelReady=1 -> exactly 307200 transfers. FrameLast on the last one, then DrainDone=01. Addresses span 0..19199.
- Random PixelReady (50%) -> pixel sequence identical to the first scenario; outputs stable during stalls.
- GlobalFlag 01 then 10 mid-frame -> image 0 completes, then image 1 streams from address 32768, ImageId=1. DrainDone=11 at end.
- GlobalFlag 11, or 01 held steady for 1000 cycles -> no extra frames after the first.
- Assert reset at pixel 5000 of image 1 -> all outputs 0 within the same cycle. No pixels after release until a new GlobalFlag edge.

Source files
------------

// File: rtl/hist_pkg.sv
// Shared constants, flag encodings and drain FSM states for the output-SRAM readback path.
package hist_pkg;

  localparam int AddressSize  = 16;
  localparam int DataBusSize  = 128;
  localparam int PixelWidth   = 8;
  localparam int LanesPerWord = DataBusSize / PixelWidth;
  localparam int LaneW        = $clog2(LanesPerWord);
  localparam int CountW       = 15;

  localparam logic [AddressSize-1:0] IMAGE_BASE0 = 16'd0;
  localparam logic [AddressSize-1:0] IMAGE_BASE1 = 16'd32768;
  localparam int                     IMAGE_WORDS = 19200;

  localparam logic [1:0] FLAG_IMG0 = 2'b01;
  localparam logic [1:0] FLAG_IMG1 = 2'b10;

  typedef enum logic [2:0] {
    DR_IDLE,
    DR_FETCH,
    DR_LOAD,
    DR_STREAM,
    DR_DONE
  } drain_state_t;

endpackage

// File: rtl/output_drain_word_unpacker.sv
// Current/next SRAM word holding registers and the MSB-first pixel lane select.
module word_unpacker
  import hist_pkg::*;
(
  input  logic                   clock,
  input  logic [DataBusSize-1:0] readBus,
  input  logic                   loadCur,
  input  logic                   captureNext,
  input  logic                   swapNext,
  input  logic [LaneW-1:0]       lane,
  output logic [PixelWidth-1:0]  pixel
);

  logic [DataBusSize-1:0] curWord;
  logic [DataBusSize-1:0] nextWord;
  logic [LanesPerWord-1:0][PixelWidth-1:0] lanes;

  always_ff @(posedge clock) begin
    if (loadCur) begin
      curWord <= readBus;
    end else if (swapNext) begin
      curWord <= nextWord;
    end
    if (captureNext) begin
      nextWord <= readBus;
    end
  end

  // Lane 0 is the top byte; with 16 lanes, (15 - lane) is simply ~lane.
  assign lanes = curWord;
  assign pixel = lanes[~lane];

endmodule

// File: rtl/output_drain.sv
// Streams a finished image back out of the output SRAM as pixels over valid/ready,
// triggered by completion edges on GlobalFlag with a one-deep pending request.
module output_drain
  import hist_pkg::*;
#(
  parameter logic [AddressSize-1:0] Base0    = IMAGE_BASE0,
  parameter logic [AddressSize-1:0] Base1    = IMAGE_BASE1,
  parameter int                     NumWords = IMAGE_WORDS
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [1:0]             GlobalFlag,
  output logic [AddressSize-1:0] ReadAddressOut,
  input  logic [DataBusSize-1:0] ReadBusOut,
  output logic [PixelWidth-1:0]  PixelOut,
  output logic                   PixelValid,
  input  logic                   PixelReady,
  output logic                   FrameFirst,
  output logic                   FrameLast,
  output logic                   ImageId,
  output logic [1:0]             DrainDone
);

  localparam logic [CountW-1:0] LastIdx  = CountW'(NumWords - 1);
  localparam logic [LaneW-1:0]  LastLane = LaneW'(LanesPerWord - 1);

  drain_state_t state, stateNext;

  logic [1:0]             gfQ;
  logic                   armed;
  logic                   newReq, newImg;
  logic                   pendValid, pendImg;
  logic [CountW-1:0]      count;
  logic [LaneW-1:0]       lane;
  logic                   lastWord;
  logic                   prefVld_p0, prefVld_p1;
  logic [PixelWidth-1:0]  lanePixel;
  logic [AddressSize-1:0] imgBase;
  logic                   xfer, atWordEnd, moreWords;
  logic                   startFrame, startImg, loadCur, issuePref, swapNext;

  // armed masks the first cycle after reset so a flag held through reset is not an edge.
  assign newReq    = armed && (GlobalFlag != gfQ) &&
                     ((GlobalFlag == FLAG_IMG0) || (GlobalFlag == FLAG_IMG1));
  assign newImg    = (GlobalFlag == FLAG_IMG1);
  assign xfer      = PixelValid && PixelReady;
  assign atWordEnd = (lane == LastLane);
  assign moreWords = (count < LastIdx);
  assign imgBase   = ImageId ? Base1 : Base0;

  always_comb begin
    stateNext  = state;
    startFrame = 1'b0;
    startImg   = pendValid ? pendImg : newImg;
    loadCur    = 1'b0;
    issuePref  = 1'b0;
    swapNext   = 1'b0;
    unique case (state)
      DR_IDLE: begin
        if (pendValid || newReq) begin
          startFrame = 1'b1;
          stateNext  = DR_FETCH;
        end
      end
      DR_FETCH: stateNext = DR_LOAD;
      DR_LOAD: begin
        loadCur   = 1'b1;
        issuePref = moreWords;
        stateNext = DR_STREAM;
      end
      DR_STREAM: begin
        if (xfer && atWordEnd) begin
          if (lastWord) begin
            stateNext = DR_DONE;
          end else begin
            swapNext  = 1'b1;
            issuePref = moreWords;
          end
        end
      end
      DR_DONE: stateNext = DR_IDLE;
      default: stateNext = DR_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= DR_IDLE;
      gfQ            <= 2'b00;
      armed          <= 1'b0;
      pendValid      <= 1'b0;
      pendImg        <= 1'b0;
      ImageId        <= 1'b0;
      ReadAddressOut <= '0;
      count          <= '0;
      lane           <= '0;
      lastWord       <= 1'b0;
      PixelValid     <= 1'b0;
      FrameFirst     <= 1'b0;
      DrainDone      <= 2'b00;
      prefVld_p0     <= 1'b0;
      prefVld_p1     <= 1'b0;
    end else begin
      state      <= stateNext;
      gfQ        <= GlobalFlag;
      armed      <= 1'b1;
      prefVld_p0 <= issuePref;
      prefVld_p1 <= prefVld_p0;

      // Serving the pending slot frees it for a request arriving the same cycle.
      if (startFrame) begin
        pendValid <= pendValid && newReq;
        if (newReq) pendImg <= newImg;
      end else if (newReq && !pendValid) begin
        pendValid <= 1'b1;
        pendImg   <= newImg;
      end

      if (startFrame) begin
        ImageId        <= startImg;
        ReadAddressOut <= startImg ? Base1 : Base0;
        count          <= '0;
      end
      if (issuePref) begin
        count          <= count + 1'b1;
        ReadAddressOut <= imgBase + AddressSize'(count + 1'b1);
      end

      if (xfer) begin
        FrameFirst <= 1'b0;
        lane       <= lane + 1'b1;
      end
      // count indexes the most recently fetched word, i.e. the one about to become current.
      if (loadCur) begin
        lane       <= '0;
        PixelValid <= 1'b1;
        FrameFirst <= 1'b1;
        lastWord   <= (count == LastIdx);
      end
      if (swapNext) begin
        lastWord <= (count == LastIdx);
      end
      if ((state == DR_STREAM) && (stateNext == DR_DONE)) begin
        PixelValid <= 1'b0;
      end
      if (state == DR_DONE) begin
        DrainDone[ImageId] <= 1'b1;
      end
    end
  end

  word_unpacker u_unpacker (
    .clock       (clock),
    .readBus     (ReadBusOut),
    .loadCur     (loadCur),
    .captureNext (prefVld_p1),
    .swapNext    (swapNext),
    .lane        (lane),
    .pixel       (lanePixel)
  );

  assign PixelOut  = PixelValid ? lanePixel : '0;
  assign FrameLast = PixelValid && lastWord && atWordEnd;

endmodule
